// File: rtl/fifo_uart_drain_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_drain_if
// Read-side bundle between a byte FIFO and its consumer.
//   fifo_empty : FIFO empty flag (driven by the FIFO)
//   fifo_data  : registered FIFO read data, valid the cycle after a sampled read
//   fifo_rd_en : one-cycle read request (driven by the consumer)
// Modports:
//   master : the consumer (fifo_uart_drain) side
//   slave  : the FIFO side
// -----------------------------------------------------------------------------
interface fifo_uart_drain_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_uart_drain.sv
// -----------------------------------------------------------------------------
// fifo_uart_drain
// Drains a byte FIFO onto an 8N1 UART-style serial line.  When enabled and the
// FIFO is not empty it pulses a one-cycle read request, captures the registered
// read data two edges later and shifts it out: one start bit (0), eight data
// bits LSB first, one stop bit (1), each held CLKS_PER_BIT clocks.
//
// Parameters:
//   CLKS_PER_BIT : clocks per serial bit (>= 4)
//
// Ports:
//   clk     : rising-edge clock
//   rstn    : asynchronous active-low reset
//   enable  : permits new FIFO fetches (checked only at fetch decision points)
//   fifo_if : FIFO read side (master modport: fifo_empty, fifo_data, fifo_rd_en)
//   tx      : registered serial line, idles high
//   busy    : high whenever the controller is not in IDLE
//
// Build option:
//   TX_PREFETCH_EN : when defined, a one-entry hold register is filled during
//                    the stop bit so consecutive frames go out with no gap.
// -----------------------------------------------------------------------------
module fifo_uart_drain #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    fifo_uart_drain_if.master  fifo_if,
    output logic               tx,
    output logic               busy
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [2:0]     BIT_LAST  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_CAPTURE = 3'd2,
        S_START   = 3'd3,
        S_DATA    = 3'd4,
        S_STOP    = 3'd5
    } state_e;

    state_e          state_q,      state_d;
    logic            fifo_rd_en_q, fifo_rd_en_d;
    logic            tx_q,         tx_d;
    logic [CW-1:0]   clk_cnt_q,    clk_cnt_d;
    logic [2:0]      bit_cnt_q,    bit_cnt_d;
    logic [7:0]      shift_q,      shift_d;

    logic            cnt_done_s;
    logic [2:0]      bit_nxt_s;

`ifdef TX_PREFETCH_EN
    logic [7:0]      hold_q,       hold_d;
    logic            hold_valid_q, hold_valid_d;
    // Marks the cycle in which the FIFO samples a prefetch read, so the byte
    // is taken from fifo_data on the following edge.
    logic            pf_cap_q,     pf_cap_d;
`endif

    // Bit-period and bit-index helpers shared by the next-state logic.
    assign cnt_done_s = (clk_cnt_q == CNT_MAX);
    assign bit_nxt_s  = bit_cnt_q + 3'd1;

    // Next-state and output computation for the drain/serialiser FSM.
    always_comb begin
        state_d      = state_q;
        fifo_rd_en_d = 1'b0;
        tx_d         = tx_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
`ifdef TX_PREFETCH_EN
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        // A read request seen while in STOP can only be a prefetch read.
        pf_cap_d     = fifo_rd_en_q && (state_q == S_STOP);
        if (pf_cap_q) begin
            hold_d       = fifo_if.fifo_data;
            hold_valid_d = 1'b1;
        end else begin
            hold_d       = hold_q;
        end
`endif

        case (state_q)
            S_IDLE: begin
                tx_d      = 1'b1;
                clk_cnt_d = CNT_ZERO;
                if (enable && !fifo_if.fifo_empty) begin
                    fifo_rd_en_d = 1'b1;
                    state_d      = S_REQ;
                end else begin
                    state_d      = S_IDLE;
                end
            end

            // The FIFO samples the request on this edge; data follows next cycle.
            S_REQ: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                shift_d   = fifo_if.fifo_data;
                tx_d      = 1'b0;
                bit_cnt_d = 3'd0;
                clk_cnt_d = CNT_ZERO;
                state_d   = S_START;
            end

            S_START: begin
                if (cnt_done_s) begin
                    clk_cnt_d = CNT_ZERO;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (cnt_done_s) begin
                    clk_cnt_d = CNT_ZERO;
                    if (bit_cnt_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_nxt_s;
                        tx_d      = shift_q[bit_nxt_s];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
`ifdef TX_PREFETCH_EN
                // Fetch the next byte early so it is ready when STOP ends.
                if ((clk_cnt_q == CNT_ZERO) && enable &&
                    !fifo_if.fifo_empty && !hold_valid_q) begin
                    fifo_rd_en_d = 1'b1;
                end else begin
                    fifo_rd_en_d = 1'b0;
                end
`endif
                if (cnt_done_s) begin
                    clk_cnt_d = CNT_ZERO;
`ifdef TX_PREFETCH_EN
                    if (hold_valid_q) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        tx_d         = 1'b0;
                        bit_cnt_d    = 3'd0;
                        state_d      = S_START;
                    end else begin
                        state_d      = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end

            default: begin
                tx_d      = 1'b1;
                clk_cnt_d = CNT_ZERO;
                bit_cnt_d = 3'd0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State, line and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            fifo_rd_en_q <= 1'b0;
            tx_q         <= 1'b1;
            clk_cnt_q    <= CNT_ZERO;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            tx_q         <= tx_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
        end
    end

`ifdef TX_PREFETCH_EN
    // Prefetch hold register and its capture pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            pf_cap_q     <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            pf_cap_q     <= pf_cap_d;
        end
    end
`endif

    assign fifo_if.fifo_rd_en = fifo_rd_en_q;
    assign tx                 = tx_q;
    assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_drain.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_drain
// Directed bench for fifo_uart_drain with CLKS_PER_BIT=4.  A small FIFO model
// feeds the design; every byte pushed is also queued as an expected frame.  An
// independent line monitor detects start bits, checks every cycle of each
// frame against the expected byte and decodes the data mid-bit.  A read-strobe
// monitor logs read pulses and checks they never hit an empty FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_uart_drain;

    localparam int CPB = 4;
`ifdef TX_PREFETCH_EN
    localparam int EXP_GAP = 10 * CPB;
`else
    localparam int EXP_GAP = 10 * CPB + 3;
`endif

    logic clk;
    logic rstn;
    logic enable;
    logic tx;
    logic busy;

    fifo_uart_drain_if ifc ();

    fifo_uart_drain #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (enable),
        .fifo_if (ifc.master),
        .tx      (tx),
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] mem [0:31];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    logic [7:0] exp_q[$];
    int         starts[$];
    int         rd_cycles[$];

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered read data, one byte per sampled read request
    always @(posedge clk) begin
        if (ifc.fifo_rd_en && (rd_ptr != wr_ptr)) begin
            ifc.fifo_data <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end
    assign ifc.fifo_empty = (rd_ptr == wr_ptr);

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    // Read-strobe monitor: log pulses, check width and non-empty FIFO
    initial begin : rd_mon
        logic prev_rd;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.fifo_rd_en === 1'b1) begin
                rd_cycles.push_back(cyc);
                check_bit("rd_en_single_cycle", prev_rd, 1'b0);
                check_bit("rd_en_fifo_nonempty", ifc.fifo_empty, 1'b0);
            end
            prev_rd = ifc.fifo_rd_en;
        end
    end

    task automatic frame_monitor();
        logic [7:0] exp_b;
        logic [7:0] got;
        logic [9:0] bits;
        int         bad;
        bit         aborted;
        starts.push_back(cyc);
        exp_b = 8'h00;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got a start bit at cycle %0d expected none", cyc);
        end else begin
            exp_b = exp_q.pop_front();
        end
        bits    = {1'b1, exp_b, 1'b0};
        got     = 8'h00;
        bad     = 0;
        aborted = 1'b0;
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c != 0) @(negedge clk);
            if (!rstn) begin
                aborted = 1'b1;
                break;
            end
            if (tx !== bits[c / CPB]) bad++;
            if ((c % CPB == CPB / 2) && (c / CPB >= 1) && (c / CPB <= 8))
                got[c / CPB - 1] = tx;
        end
        if (!aborted) begin
            check_int("frame_bad_cycles", bad, 0);
            check_int("frame_byte", int'(got), int'(exp_b));
        end
    endtask

    // Line monitor: detect start bits and check whole frames
    initial begin : tx_mon
        logic prev_tx;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_tx = 1'b1;
            end else if (prev_tx && (tx === 1'b0)) begin
                frame_monitor();
                prev_tx = 1'b1;
            end else begin
                prev_tx = tx;
            end
        end
    end

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (!((rd_ptr == wr_ptr) && (busy === 1'b0)) && (n < max_cyc)) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_starts(input int target, input int max_cyc);
        int n;
        n = 0;
        while ((starts.size() < target) && (n < max_cyc)) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: got %0d starts expected %0d", starts.size(), target);
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin : stim
        int n_rd;
        int n_st;
        int bad;

        // 1. Reset with data present and enable high
        rstn   = 1'b0;
        enable = 1'b1;
        push_byte(8'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("reset_tx", tx, 1'b1);
            check_bit("reset_rd_en", ifc.fifo_rd_en, 1'b0);
            check_bit("reset_busy", busy, 1'b0);
        end
        rstn = 1'b1;

        // 2. Single byte 0xA5
        wait_drain(200);
        check_int("single_rd_count", rd_cycles.size(), 1);
        check_int("single_starts", starts.size(), 1);
        if ((rd_cycles.size() >= 1) && (starts.size() >= 1))
            check_int("single_latency", starts[0] - rd_cycles[0], 2);
        check_bit("single_idle_busy", busy, 1'b0);
        check_bit("single_idle_tx", tx, 1'b1);

        // 3. Two bytes back to back
        n_rd = rd_cycles.size();
        n_st = starts.size();
        push_byte(8'h01);
        push_byte(8'h80);
        wait_drain(300);
        check_int("two_rd_count", rd_cycles.size() - n_rd, 2);
        check_int("two_starts", starts.size() - n_st, 2);
        if (starts.size() >= n_st + 2)
            check_int("two_start_gap", starts[n_st + 1] - starts[n_st], EXP_GAP);

        // 4. Empty FIFO with enable high
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((ifc.fifo_rd_en !== 1'b0) || (tx !== 1'b1) || (busy !== 1'b0)) bad++;
        end
        check_int("empty_idle_bad_cycles", bad, 0);

        // 5. Enable dropped during data bit 2 of the first of three bytes
        n_rd = rd_cycles.size();
        n_st = starts.size();
        push_byte(8'h3C);
        push_byte(8'hC3);
        push_byte(8'h5A);
        wait_starts(n_st + 1, 100);
        repeat (3 * CPB + 1) @(negedge clk);
        enable = 1'b0;
        repeat (10 * CPB + 20) @(negedge clk);
        check_int("endrop_rd_count", rd_cycles.size() - n_rd, 1);
        check_int("endrop_starts", starts.size() - n_st, 1);
        check_bit("endrop_busy", busy, 1'b0);
        enable = 1'b1;
        wait_drain(400);
        check_int("resume_rd_count", rd_cycles.size() - n_rd, 3);
        check_int("resume_starts", starts.size() - n_st, 3);

        // 6. Reset during data bit 3
        n_st = starts.size();
        push_byte(8'h96);
        push_byte(8'h69);
        wait_starts(n_st + 1, 100);
        repeat (4 * CPB + 1) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_bit("midreset_tx", tx, 1'b1);
        check_bit("midreset_busy", busy, 1'b0);
        check_bit("midreset_rd_en", ifc.fifo_rd_en, 1'b0);
        repeat (3) @(negedge clk);
        n_rd = rd_cycles.size();
        n_st = starts.size();
        rstn = 1'b1;
        wait_drain(200);
        check_int("postreset_rd_count", rd_cycles.size() - n_rd, 1);
        check_int("postreset_starts", starts.size() - n_st, 1);
        if ((rd_cycles.size() > n_rd) && (starts.size() > n_st))
            check_int("postreset_latency", starts[n_st] - rd_cycles[n_rd], 2);

        check_int("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
